// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle multiply/divide engine that owns HI/LO and stalls the pipeline while iterating
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_op, i_start        request code and valid (multu/mul/div/divu long, mthi/mtlo short)
//   i_a, i_b             rs / rt operands
//   i_hilo_rd            mfhi/mflo currently in EX
//   o_hi, o_lo           HI/LO registers
//   o_mul_out            low word of the last signed mul product
//   o_busy, o_done       iteration flag, retire pulse (high for the FIN cycle)
//   o_stall              combinational freeze request to IF/ID/EX
// Build option: MULDIV_ZERO_SKIP_EN jumps straight to FIN when an operand is zero.
module muldiv_sequencer (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [2:0]  i_op,
   input  logic        i_start,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_hilo_rd,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo,
   output logic [31:0] o_mul_out,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_stall
);
   localparam logic [2:0] OP_MULTU = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3, OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
   state_t      r_state, w_next;
   logic [5:0]  r_cnt;
   logic [2:0]  r_op;
   logic [63:0] r_p;
   logic [31:0] r_d, r_a, r_hi, r_lo, r_mul;
   logic        r_neg, r_sa, r_dz, r_busy;
   logic        w_long, w_short, w_accept, w_skip, w_signed_in, w_mul_in, w_is_mul, w_ge;
   logic [31:0] w_ma, w_mb, w_q, w_r;
   logic [32:0] w_sum, w_rsh, w_diff;
   assign w_long      = i_op == OP_MULTU || i_op == OP_MUL || i_op == OP_DIV || i_op == OP_DIVU;
   assign w_short     = i_op == OP_MTHI || i_op == OP_MTLO;
   assign w_accept    = i_start && w_long && r_state == S_IDLE;
   assign w_signed_in = i_op == OP_MUL || i_op == OP_DIV;
   assign w_mul_in    = i_op == OP_MULTU || i_op == OP_MUL;
   assign w_ma        = (w_signed_in && i_a[31]) ? -i_a : i_a;
   assign w_mb        = (w_signed_in && i_b[31]) ? -i_b : i_b;
`ifdef MULDIV_ZERO_SKIP_EN
   // A zero operand fixes the result: product 0, quotient/remainder 0, or the divide-by-zero pattern
   assign w_skip = i_a == 32'd0 || i_b == 32'd0;
`else
   assign w_skip = 1'b0;
`endif
   // r_p holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
   assign w_is_mul = r_op == OP_MULTU || r_op == OP_MUL;
   assign w_sum    = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_d} : 33'd0);
   assign w_rsh    = r_p[63:31];
   assign w_diff   = w_rsh - {1'b0, r_d};
   assign w_ge     = ~w_diff[32];
   // Low word of a negated 64-bit product equals the negated low word, so mul shares the quotient fixup
   assign w_q      = r_neg ? -r_p[31:0] : r_p[31:0];
   assign w_r      = r_sa ? -r_p[63:32] : r_p[63:32];
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next  = r_state;
      o_done  = r_state == S_FIN;
      o_stall = w_accept || r_state == S_RUN || r_state == S_FIN ||
                (i_hilo_rd && r_state != S_IDLE) || (i_start && w_short && r_state != S_IDLE);
      unique case (r_state)
         S_IDLE:  if (w_accept) w_next = w_skip ? S_FIN : S_RUN;
         S_RUN:   if (r_cnt == 6'd31) w_next = S_FIN;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_op   <= '0;
         r_p    <= '0;
         r_d    <= '0;
         r_a    <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_mul  <= '0;
         r_neg  <= 1'b0;
         r_sa   <= 1'b0;
         r_dz   <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         r_busy <= r_state == S_RUN;
         if (r_state == S_IDLE) begin
            if (w_accept) begin
               r_cnt <= '0;
               r_op  <= i_op;
               r_p   <= w_skip ? 64'd0 : {32'd0, w_mul_in ? w_mb : w_ma};
               r_d   <= w_mul_in ? w_ma : w_mb;
               r_a   <= i_a;
               r_neg <= w_signed_in && (i_a[31] ^ i_b[31]);
               r_sa  <= w_signed_in && i_a[31];
               r_dz  <= !w_mul_in && i_b == 32'd0;
            end else if (i_start && i_op == OP_MTHI) r_hi <= i_a;
            else if (i_start && i_op == OP_MTLO) r_lo <= i_a;
         end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 6'd1;
            r_p   <= w_is_mul ? {w_sum, r_p[31:1]} : {w_ge ? w_diff[31:0] : w_rsh[31:0], r_p[30:0], w_ge};
         end else begin
            r_cnt <= '0;
            if (r_op == OP_MULTU) {r_hi, r_lo} <= r_p;
            else if (r_op == OP_MUL) r_mul <= w_q;
            else if (r_dz) begin
               r_lo <= 32'hFFFF_FFFF;
               r_hi <= r_a;
            end else begin
               r_lo <= w_q;
               r_hi <= w_r;
            end
         end
      end
   end
   assign o_hi      = r_hi;
   assign o_lo      = r_lo;
   assign o_mul_out = r_mul;
   assign o_busy    = r_busy;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, hilo_rd = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = '0, b = '0, hi, lo, mul_out;
   logic        busy, done, stall;
   int          n_chk = 0, n_err = 0;
`ifdef MULDIV_ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif
   always #5 clk = ~clk;
   muldiv_sequencer dut (
      .i_clk(clk), .i_rst(rst), .i_op(op), .i_start(start), .i_a(a), .i_b(b), .i_hilo_rd(hilo_rd),
      .o_hi(hi), .o_lo(lo), .o_mul_out(mul_out), .o_busy(busy), .o_done(done), .o_stall(stall)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask
   task automatic run_long(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      int n_stall, n_done, n_busy, lim;
      bit z;
      z = SKIP && (x == 0 || y == 0);
      @(posedge clk); #1;
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      chk({tag, "_stall_start"}, stall, 1);
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0;
      n_stall = 0; n_done = 0; n_busy = 0; lim = 0;
      @(negedge clk);
      while (stall && lim < 100) begin
         n_stall++;
         n_done += int'(done);
         n_busy += int'(busy);
         lim++;
         @(negedge clk);
      end
      chk({tag, "_stall_after_accept"}, n_stall, z ? 1 : 33);
      chk({tag, "_done_cycles"}, n_done, 1);
      chk({tag, "_busy_cycles"}, n_busy, z ? 0 : 32);
   endtask
   initial begin
      int n_done, lim;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_mul", mul_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_stall", stall, 0);
      @(posedge clk); #1 rst = 1'b0;
      run_long("multu", 3'd1, 32'hFFFF_FFFF, 32'd2);
      chk("multu_hi", hi, 32'h1);
      chk("multu_lo", lo, 32'hFFFF_FFFE);
      run_long("mul", 3'd2, 32'hFFFF_FFFD, 32'd5);
      chk("mul_out", mul_out, 32'hFFFF_FFF1);
      chk("mul_hi_kept", hi, 32'h1);
      chk("mul_lo_kept", lo, 32'hFFFF_FFFE);
      run_long("mul2", 3'd2, 32'h0001_2345, 32'hFFFF_FFFE);
      chk("mul2_out", mul_out, 32'hFFFD_B976);
      run_long("div", 3'd3, 32'hFFFF_FFF9, 32'd2);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);
      run_long("div_pos_neg", 3'd3, 32'd7, 32'hFFFF_FFFE);
      chk("div_pn_lo", lo, 32'hFFFF_FFFD);
      chk("div_pn_hi", hi, 32'd1);
      run_long("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_ovf_lo", lo, 32'h8000_0000);
      chk("div_ovf_hi", hi, 32'd0);
      run_long("divu", 3'd4, 32'd100, 32'd7);
      chk("divu_lo", lo, 32'd14);
      chk("divu_hi", hi, 32'd2);
      run_long("divu0", 3'd4, 32'd100, 32'd0);
      chk("divu0_lo", lo, 32'hFFFF_FFFF);
      chk("divu0_hi", hi, 32'd100);
      run_long("multu_big", 3'd1, 32'h0001_0000, 32'h0001_0000);
      chk("multu_big_hi", hi, 32'd1);
      chk("multu_big_lo", lo, 32'd0);
      // reserved opcode does nothing
      @(posedge clk); #1 op = 3'd7; a = 32'hDEAD_BEEF; start = 1'b1;
      @(negedge clk);
      chk("rsv_stall", stall, 0);
      @(posedge clk); #1 start = 1'b0; op = 3'd0;
      @(negedge clk);
      chk("rsv_hi", hi, 32'd1);
      chk("rsv_busy", busy, 0);
      // mthi then an immediate mfhi
      @(posedge clk); #1 op = 3'd5; a = 32'h1234_5678; start = 1'b1;
      @(negedge clk);
      chk("mthi_stall", stall, 0);
      @(posedge clk); #1 start = 1'b0; op = 3'd0; hilo_rd = 1'b1;
      @(negedge clk);
      chk("mthi_hi", hi, 32'h1234_5678);
      chk("mfhi_stall", stall, 0);
      @(posedge clk); #1 hilo_rd = 1'b0;
      // mtlo presented while a div is iterating
      op = 3'd3; a = 32'd20; b = 32'd3; start = 1'b1;
      @(posedge clk); #1 op = 3'd6; a = 32'hCAFE_BABE; hilo_rd = 1'b1;
      @(negedge clk);
      chk("mtlo_run_stall", stall, 1);
      lim = 0;
      while (stall && lim < 100) begin
         lim++;
         @(negedge clk);
      end
      chk("mtlo_wait_bounded", lim < 100, 1);
      chk("mtlo_lo_div", lo, 32'd6);
      chk("mtlo_hi_div", hi, 32'd2);
      chk("mtlo_idle_stall", stall, 0);
      @(posedge clk); #1 start = 1'b0; op = 3'd0; hilo_rd = 1'b0;
      @(negedge clk);
      chk("mtlo_lo", lo, 32'hCAFE_BABE);
      chk("mtlo_hi_kept", hi, 32'd2);
      // reset at RUN step 10
      @(posedge clk); #1 op = 3'd3; a = 32'd100; b = 32'd3; start = 1'b1;
      @(posedge clk); #1 start = 1'b0; op = 3'd0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_hi", hi, 0);
      chk("abort_lo", lo, 0);
      chk("abort_busy", busy, 0);
      chk("abort_stall", stall, 0);
      n_done = 0;
      repeat (40) begin
         n_done += int'(done);
         @(negedge clk);
      end
      chk("abort_no_done", n_done, 0);
      chk("abort_hi_after", hi, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
